alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle execute ALU.
- Sits in the execute stage between decode/register-read and writeback.
- Valid/ready handshakes on input and output, so the pipeline can stall it and it can stall the pipeline.
- Single-cycle ops complete in 1 cycle; DIV/REM use an iterative restoring divider (1 quotient bit per cycle), so no combinational divider is synthesised.

---
 rtl/alu_mc_if.sv | 42 ++++
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle execute ALU.
//   master : upstream/downstream pipeline side. It drives the request
//            (in_valid, opcode, value1, value2, in_tag) and out_ready.
//   slave  : the ALU. It drives in_ready, out_valid, result and out_tag.
// Optional macro ALU_MC_FLAGS_EN adds the zero_flag and carry_flag signals.
interface alu_mc_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       opcode;
   logic [WIDTH-1:0] value1;
   logic [WIDTH-1:0] value2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
`ifdef ALU_MC_FLAGS_EN
   logic             zero_flag;
   logic             carry_flag;

   modport master (
      output in_valid, opcode, value1, value2, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, zero_flag, carry_flag
   );
   modport slave (
      input  in_valid, opcode, value1, value2, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, zero_flag, carry_flag
   );
`else
   modport master (
      output in_valid, opcode, value1, value2, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag
   );
   modport slave (
      input  in_valid, opcode, value1, value2, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag
   );
`endif
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops have a latency of 1. DIV and REM use a restoring divider
// that produces one quotient bit per cycle, so their latency is WIDTH+1.
// The result register and the tag are held while downstream stalls.
// Ports:
//   clk     : rising-edge clock.
//   reset_n : asynchronous active-low reset.
//   bus     : alu_mc_if.slave. The request side is in_valid/in_ready/opcode/
//             value1/value2/in_tag. The response side is
//             out_valid/out_ready/result/out_tag.
// Optional macro ALU_MC_FLAGS_EN adds registered zero_flag and carry_flag.
module alu_mc #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 5
) (
   input  logic     clk,
   input  logic     reset_n,
   alu_mc_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_MUL = 5'd2;
   localparam logic [4:0] OP_DIV = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_AND = 5'd5;
   localparam logic [4:0] OP_OR  = 5'd6;
   localparam logic [4:0] OP_REM = 5'd7;
   localparam logic [4:0] OP_NOT = 5'd8;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [TAG_W-1:0] r_out_tag;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_divisor;
   logic [CNT_W-1:0] r_count;
   logic             r_is_rem;
   logic [TAG_W-1:0] r_tag;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_is_div;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_rem_sub;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quot_next;
   logic [WIDTH-1:0] w_div_res;

   // The output slot is free when it is empty or is being drained on this edge.
   assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_is_div   = (bus.opcode == OP_DIV) || (bus.opcode == OP_REM);
   assign w_div_zero = (bus.value2 == '0);

   // Single-cycle datapath. DIV and REM only reach this path when value2 is zero.
   always_comb begin
      w_alu = bus.value1;
      case (bus.opcode)
         OP_ADD:  w_alu = bus.value1 + bus.value2;
         OP_SUB:  w_alu = bus.value1 - bus.value2;
         OP_MUL:  w_alu = bus.value1 * bus.value2;
         OP_DIV:  w_alu = '1;
         OP_XOR:  w_alu = bus.value1 ^ bus.value2;
         OP_AND:  w_alu = bus.value1 & bus.value2;
         OP_OR:   w_alu = bus.value1 | bus.value2;
         OP_REM:  w_alu = bus.value1;
         OP_NOT:  w_alu = ~bus.value1;
         default: w_alu = bus.value1;
      endcase
   end

   // One restoring step. The partial remainder is WIDTH+1 bits wide after the
   // shift, and no borrow from the subtract means rem >= divisor.
   assign w_rem_sh    = {r_rem, r_quot[WIDTH-1]};
   assign w_rem_sub   = w_rem_sh - {1'b0, r_divisor};
   assign w_ge        = !w_rem_sub[WIDTH];
   assign w_rem_next  = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};
   assign w_div_res   = r_is_rem ? r_rem : r_quot;

`ifdef ALU_MC_FLAGS_EN
   logic           r_zero_flag;
   logic           r_carry_flag;
   logic           w_carry;
   logic [WIDTH:0] w_sum_x;
   logic [WIDTH:0] w_diff_x;

   assign w_sum_x  = {1'b0, bus.value1} + {1'b0, bus.value2};
   assign w_diff_x = {1'b0, bus.value1} - {1'b0, bus.value2};

   // Carry or borrow for ADD and SUB. For DIV and REM the flag marks divide-by-zero.
   always_comb begin
      w_carry = 1'b0;
      case (bus.opcode)
         OP_ADD:         w_carry = w_sum_x[WIDTH];
         OP_SUB:         w_carry = w_diff_x[WIDTH];
         OP_DIV, OP_REM: w_carry = w_div_zero;
         default:        w_carry = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_zero_flag  <= 1'b0;
         r_carry_flag <= 1'b0;
      end else if (r_state == S_IDLE && w_accept && !(w_is_div && !w_div_zero)) begin
         r_zero_flag  <= (w_alu == '0);
         r_carry_flag <= w_carry;
      end else if (r_state == S_DONE) begin
         r_zero_flag  <= (w_div_res == '0);
         r_carry_flag <= 1'b0;
      end
   end

   assign bus.zero_flag  = r_zero_flag;
   assign bus.carry_flag = r_carry_flag;
`endif

   // Control and result registers. A reset during DIVIDE or DONE drops the divide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_out_tag   <= '0;
         r_rem       <= '0;
         r_quot      <= '0;
         r_divisor   <= '0;
         r_count     <= '0;
         r_is_rem    <= 1'b0;
         r_tag       <= '0;
      end else begin
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_div && !w_div_zero) begin
                     r_rem     <= '0;
                     r_quot    <= bus.value1;
                     r_divisor <= bus.value2;
                     r_count   <= CNT_W'(WIDTH - 1);
                     r_is_rem  <= (bus.opcode == OP_REM);
                     r_tag     <= bus.in_tag;
                     r_state   <= S_DIVIDE;
                  end else begin
                     r_result    <= w_alu;
                     r_out_tag   <= bus.in_tag;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DIVIDE: begin
               r_rem  <= w_rem_next;
               r_quot <= w_quot_next;
               if (r_count == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            S_DONE: begin
               r_result    <= w_div_res;
               r_out_tag   <= r_tag;
               r_out_valid <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.out_tag   = r_out_tag;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=64, TAG_W=5).
// Inputs change on the falling edge of clk, and outputs are sampled there too.
module tb_alu_mc;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned TAG_W = 5;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   alu_mc_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   alu_mc #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one single-cycle op, then check its result on the following edge.
   task automatic single_op(input string name, input logic [4:0] op,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag, input logic [63:0] exp,
                            input logic exp_c);
      bus.in_valid  = 1'b1;
      bus.opcode    = op;
      bus.value1    = a;
      bus.value2    = b;
      bus.in_tag    = tag;
      bus.out_ready = 1'b1;
      #1;
      chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, "_result"}, bus.result, exp);
      chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
`ifdef ALU_MC_FLAGS_EN
      chk({name, "_zero"}, 64'(bus.zero_flag), 64'(exp == 64'd0));
      chk({name, "_carry"}, 64'(bus.carry_flag), 64'(exp_c));
`else
      if (exp_c === 1'bx) $display("note: unknown carry for %s", name);
`endif
   endtask

   // Issue a divide and measure how many edges pass from the accept to out_valid.
   task automatic div_op(input string name, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic [63:0] exp);
      int lat;
      int busy_bad;
      bus.in_valid  = 1'b1;
      bus.opcode    = op;
      bus.value1    = a;
      bus.value2    = b;
      bus.in_tag    = tag;
      bus.out_ready = 1'b1;
      #1;
      chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat      = 0;
      busy_bad = 0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready !== 1'b0) busy_bad++;
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd65);
      chk({name, "_busy_in_ready"}, 64'(busy_bad), 64'd0);
      chk({name, "_result"}, bus.result, exp);
      chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
   endtask

   initial begin
      int bad;
      checks        = 0;
      errors        = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.opcode    = 5'd0;
      bus.value1    = '0;
      bus.value2    = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", bus.result, 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Back-to-back throughput
      single_op("add", 5'd0, 64'd5, 64'd7, 5'd3, 64'd12, 1'b0);
      single_op("sub", 5'd1, 64'd3, 64'd5, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      @(negedge clk);
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

      // Divide latency, then a REM accepted on the DIV output handshake
      div_op("div", 5'd3, 64'd100, 64'd7, 5'd5, 64'd14);
      div_op("rem", 5'd7, 64'd100, 64'd7, 5'd6, 64'd2);
      @(negedge clk);
      chk("div_drain_valid", 64'(bus.out_valid), 64'd0);

      // Divide by zero
      single_op("div0", 5'd3, 64'd9, 64'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      single_op("rem0", 5'd7, 64'd9, 64'd0, 5'd2, 64'd9, 1'b1);
      @(negedge clk);

      // Output backpressure
      bus.in_valid  = 1'b1;
      bus.opcode    = 5'd2;
      bus.value1    = 64'h0000_0001_0000_0000;
      bus.value2    = 64'h0000_0001_0000_0001;
      bus.in_tag    = 5'd9;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("mul_result", bus.result, 64'h0000_0001_0000_0000);
      chk("mul_valid", 64'(bus.out_valid), 64'd1);
      bus.opcode = 5'd0;
      bus.value1 = 64'd1;
      bus.value2 = 64'd2;
      bus.in_tag = 5'd10;
      bad = 0;
      repeat (4) begin
         #1;
         if (bus.in_ready !== 1'b0) bad++;
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.result !== 64'h0000_0001_0000_0000 ||
             bus.out_tag !== 5'd9) bad++;
      end
      chk("bp_hold", 64'(bad), 64'd0);
      chk("bp_tag", 64'(bus.out_tag), 64'd9);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_next_result", bus.result, 64'd3);
      chk("bp_next_tag", 64'(bus.out_tag), 64'd10);
      chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);

      // Reset mid-divide
      bus.in_valid = 1'b1;
      bus.opcode   = 5'd3;
      bus.value1   = 64'd50;
      bus.value2   = 64'd5;
      bus.in_tag   = 5'd11;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_result", bus.result, 64'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_result", bus.result, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      bad = 0;
      repeat (70) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) bad++;
      end
      chk("no_stale_output", 64'(bad), 64'd0);

      // Misc ops
      single_op("not0", 5'd8, 64'd0, 64'h1234, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      single_op("op15", 5'd15, 64'hABCD, 64'd77, 5'd13, 64'hABCD, 1'b0);
      single_op("add_wrap", 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd14, 64'd0, 1'b1);
      single_op("xor", 5'd4, 64'hF0, 64'hFF, 5'd15, 64'h0F, 1'b0);
      single_op("and", 5'd5, 64'hF0, 64'h3C, 5'd16, 64'h30, 1'b0);
      single_op("or", 5'd6, 64'hF0, 64'h0F, 5'd17, 64'hFF, 1'b0);
      @(negedge clk);
      chk("end_out_valid", 64'(bus.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
